// File: rtl/shift_pkg.sv
// Shared definitions for the shift engines: default widths, op codes and the
// sequencer state encoding.
package shift_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_SHW   = 4;

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_SRL = 3'd1;
   localparam logic [2:0] OP_SRA = 3'd2;
   localparam logic [2:0] OP_ROL = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Codes above OP_ROR are reserved and reported as errors.
   function automatic logic op_is_legal(input logic [2:0] op);
      return op <= OP_ROR;
   endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/result handshake bundle between a requester (master) and the
// shift sequencer (slave).
interface shift_sequencer_if
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SHW   = DEFAULT_SHW
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_err;

   modport master (
      output in_valid, in_data, in_shamt, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_op, out_ready,
      output in_ready, out_valid, out_data, out_err
   );

endinterface

// File: rtl/shift_step.sv
// Combinational single step of a shift/rotate: moves the word by 1 or 4
// positions according to the op code; illegal codes pass data through.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] data,
   input  logic [2:0]       op,
   input  logic             step_four,
   output logic [WIDTH-1:0] next_data
);

   logic [2:0] amt;

   assign amt = step_four ? 3'd4 : 3'd1;

   always_comb begin
      next_data = data;
      case (op)
         OP_SLL:  next_data = data << amt;
         OP_SRL:  next_data = data >> amt;
         OP_SRA:  next_data = $unsigned($signed(data) >>> amt);
         OP_ROL:  next_data = (data << amt) | (data >> (WIDTH - int'(amt)));
         OP_ROR:  next_data = (data >> amt) | (data << (WIDTH - int'(amt)));
         default: next_data = data;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle handshaked shift engine, one step per cycle.
// Define SHIFT_SEQ_FAST_EN to step by 4 positions while at least 4 remain.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SHW   = DEFAULT_SHW
) (
   input  logic             clk,
   input  logic             rst,
   shift_sequencer_if.slave bus
);

   state_t           state_q;
   state_t           next_state;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] step_data;
   logic [2:0]       op_q;
   logic [SHW-1:0]   count_q;
   logic [SHW-1:0]   step_amt;
   logic             err_q;
   logic             step_four;
   logic             in_ready;
   logic             out_valid;

`ifdef SHIFT_SEQ_FAST_EN
   assign step_four = (count_q >= SHW'(4));
`else
   assign step_four = 1'b0;
`endif

   assign step_amt = step_four ? SHW'(4) : SHW'(1);

   shift_step #(.WIDTH(WIDTH)) u_step (
      .data      (data_q),
      .op        (op_q),
      .step_four (step_four),
      .next_data (step_data)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= next_state;
   end

   // The final step lands exactly on zero remaining, so DONE follows it.
   always_comb begin
      next_state = state_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               if (bus.in_shamt == '0 || !op_is_legal(bus.in_op)) next_state = DONE;
               else                                               next_state = SHIFT;
            end
         end
         SHIFT: begin
            if (count_q == step_amt) next_state = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         op_q    <= OP_SLL;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  data_q  <= bus.in_data;
                  op_q    <= bus.in_op;
                  count_q <= bus.in_shamt;
                  err_q   <= !op_is_legal(bus.in_op);
               end
            end
            SHIFT: begin
               data_q  <= step_data;
               count_q <= count_q - step_amt;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = data_q;
   assign bus.out_err   = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed, table-driven bench for shift_sequencer: results, error flag and
// latency per command, plus back-pressure and mid-operation reset sequences.
module tb_shift_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   shift_sequencer_if bus ();

   shift_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  shamt;
      logic [2:0]  op;
      logic [15:0] exp_data;
      logic        exp_err;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   function automatic int expLatency(logic [3:0] shamt, logic [2:0] op);
      int s;
      s = int'(shamt);
      if (op > 3'd4 || s == 0) return 1;
`ifdef SHIFT_SEQ_FAST_EN
      return s / 4 + s % 4 + 1;
`else
      return s + 1;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Waits (bounded) for in_ready, then presents one command for one accept edge.
   task automatic applyStimulus(input logic [15:0] data, input logic [3:0] shamt, input logic [2:0] op);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("ready_before_cmd", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_shamt = shamt;
      bus.in_op    = op;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'h5A5A;
      bus.in_shamt = 4'd7;
      bus.in_op    = 3'd1;
   endtask

   task automatic waitResult(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      checks   = 0;
      failures = 0;

      vecs[0]  = '{16'hABCD, 4'd2,  3'd0, 16'hAF34, 1'b0};
      vecs[1]  = '{16'hABCD, 4'd2,  3'd1, 16'h2AF3, 1'b0};
      vecs[2]  = '{16'hABCD, 4'd2,  3'd2, 16'hEAF3, 1'b0};
      vecs[3]  = '{16'hABCD, 4'd2,  3'd3, 16'hAF36, 1'b0};
      vecs[4]  = '{16'hABCD, 4'd2,  3'd4, 16'h6AF3, 1'b0};
      vecs[5]  = '{16'h0020, 4'd3,  3'd3, 16'h0100, 1'b0};
      vecs[6]  = '{16'h0001, 4'd15, 3'd4, 16'h0002, 1'b0};
      vecs[7]  = '{16'h8001, 4'd0,  3'd2, 16'h8001, 1'b0};
      vecs[8]  = '{16'hFFFF, 4'd15, 3'd0, 16'h8000, 1'b0};
      vecs[9]  = '{16'hFFFF, 4'd15, 3'd1, 16'h0001, 1'b0};
      vecs[10] = '{16'h8000, 4'd15, 3'd2, 16'hFFFF, 1'b0};
      vecs[11] = '{16'h8000, 4'd4,  3'd2, 16'hF800, 1'b0};
      vecs[12] = '{16'h1234, 4'd4,  3'd3, 16'h2341, 1'b0};
      vecs[13] = '{16'h1234, 4'd5,  3'd4, 16'hA091, 1'b0};
      vecs[14] = '{16'hABCD, 4'd7,  3'd2, 16'hFF57, 1'b0};
      vecs[15] = '{16'h1234, 4'd5,  3'd6, 16'h1234, 1'b1};
      vecs[16] = '{16'hBEEF, 4'd9,  3'd7, 16'hBEEF, 1'b1};

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_shamt = '0;
      bus.in_op    = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("rst_out_data",  {16'd0, bus.out_data},  32'd0);
      checkOutput("rst_out_err",   {31'd0, bus.out_err},   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].data, vecs[i].shamt, vecs[i].op);
         waitResult(lat);
         checkOutput($sformatf("vec%0d_data", i), {16'd0, bus.out_data}, {16'd0, vecs[i].exp_data});
         checkOutput($sformatf("vec%0d_err", i),  {31'd0, bus.out_err},  {31'd0, vecs[i].exp_err});
         checkOutput($sformatf("vec%0d_lat", i),  lat, expLatency(vecs[i].shamt, vecs[i].op));
         @(posedge clk); #1;
         checkOutput($sformatf("vec%0d_consumed", i), {31'd0, bus.out_valid}, 32'd0);
      end

      // Back-pressure: result must hold while a competing command is offered.
      bus.out_ready = 1'b0;
      applyStimulus(16'hABCD, 4'd1, 3'd0);
      waitResult(lat);
      checkOutput("bp_lat", lat, expLatency(4'd1, 3'd0));
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'hFFFF;
         bus.in_shamt = 4'd0;
         bus.in_op    = 3'd1;
         @(posedge clk); #1;
         checkOutput($sformatf("bp_valid%0d", k), {31'd0, bus.out_valid}, 32'd1);
         checkOutput($sformatf("bp_data%0d", k),  {16'd0, bus.out_data},  32'h579A);
         checkOutput($sformatf("bp_ready%0d", k), {31'd0, bus.in_ready},  32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_released_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("bp_released_ready", {31'd0, bus.in_ready},  32'd1);

      applyStimulus(16'h1234, 4'd3, 3'd6);
      waitResult(lat);
      checkOutput("illegal_data", {16'd0, bus.out_data}, 32'h1234);
      checkOutput("illegal_err",  {31'd0, bus.out_err},  32'd1);
      checkOutput("illegal_lat",  lat, 1);
      @(posedge clk); #1;

      // Reset in the middle of a long shift discards the command.
      applyStimulus(16'h0001, 4'd10, 3'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("midrst_busy", {31'd0, bus.in_ready}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("midrst_ready", {31'd0, bus.in_ready},  32'd1);
      checkOutput("midrst_data",  {16'd0, bus.out_data},  32'd0);
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("midrst_quiet%0d", k), {31'd0, bus.out_valid}, 32'd0);
      end
      applyStimulus(16'h0020, 4'd3, 3'd3);
      waitResult(lat);
      checkOutput("post_rst_data", {16'd0, bus.out_data}, 32'h0100);
      checkOutput("post_rst_err",  {31'd0, bus.out_err},  32'd0);
      checkOutput("post_rst_lat",  lat, expLatency(4'd3, 3'd3));
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
